osc_tick_gen: RTL

- Sits directly downstream of the on-chip oscillator block (53.20 MHz internal OSCH clock).
- Converts the raw oscillator clock into exact-average timing strobes for the rest of the design:
  - 1 us tick, via a fractional phase accumulator;
  - 1 ms tick;
  - a programmable bit-rate tick for the I2C master and the motor/PWM logic.
- Holds its outputs quiet during an oscillator settle period after reset.

---
 rtl/osc_tick_gen.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/osc_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : osc_tick_gen                                               |
// | Description : Timing strobe generator downstream of the on-chip          |
// |               oscillator. Produces an exact-average 1 us tick through a  |
// |               fractional phase accumulator, a 1 ms tick, a free-running  |
// |               ms counter and a programmable divider tick with a load     |
// |               handshake. All outputs stay quiet while the oscillator     |
// |               settles after reset.                                       |
// | Options     : define OSC_TICK_SEC_EN to build the 1 s tick (tick_s);     |
// |               otherwise tick_s is tied low.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module osc_tick_gen #(
  parameter int          CLK_FREQ_KHZ   = 53200, // 1000..131071
  parameter int          STARTUP_CYCLES = 1024,  // >= 1
  parameter int unsigned DIV_RESET      = 0      // 0 = tick_div disabled
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] div_val,
  input  logic        div_load,
  output logic        div_ack,
  output logic        ready,
  output logic        tick_us,
  output logic        tick_ms,
  output logic        tick_div,
  output logic [15:0] ms_count,
  output logic        tick_s
);

  // Settle counter is sized to hold STARTUP_CYCLES-1; a 1-cycle settle still
  // needs one bit of storage.
  localparam int                  c_settle_w    = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(STARTUP_CYCLES - 1);
  // The sum of a 17-bit phase and the 1000 step can exceed 17 bits near the
  // top of the legal frequency range, so it is evaluated with 18 bits.
  localparam logic [17:0]         c_freq        = 18'(CLK_FREQ_KHZ);
  localparam logic [17:0]         c_us_step     = 18'd1000;
  localparam logic [9:0]          c_us_last     = 10'd999;
  localparam logic [15:0]         c_div_reset   = 16'(DIV_RESET);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t                  state_q,    state_d;
  logic [c_settle_w-1:0]   settle_q,   settle_d;
  logic                    ready_q,    ready_d;
  logic [16:0]             acc_q,      acc_d;
  logic [9:0]              us_cnt_q,   us_cnt_d;
  logic [15:0]             ms_count_q, ms_count_d;
  logic                    tick_us_q,  tick_us_d;
  logic                    tick_ms_q,  tick_ms_d;
  logic [15:0]             div_reg_q,  div_reg_d;
  logic [15:0]             div_cnt_q,  div_cnt_d;
  logic                    tick_div_q, tick_div_d;
  logic                    div_ack_q,  div_ack_d;
  logic                    pend_q,     pend_d;
  logic [15:0]             pend_val_q, pend_val_d;
`ifdef OSC_TICK_SEC_EN
  logic [9:0]              sec_cnt_q,  sec_cnt_d;
  logic                    tick_s_q,   tick_s_d;
`endif

  logic                    w_active;
  logic                    w_apply;
  logic [17:0]             w_sum;
  logic [17:0]             w_wrap;

  // Counters advance only while running with en high; HOLD and SETTLE freeze them.
  assign w_active = (state_q == ST_RUN) && en;
  assign w_sum    = {1'b0, acc_q} + c_us_step;
  assign w_wrap   = w_sum - c_freq;

  // Next-state logic: FSM, phase accumulator, ms chain and divider handshake.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    ready_d    = ready_q;
    acc_d      = acc_q;
    us_cnt_d   = us_cnt_q;
    ms_count_d = ms_count_q;
    tick_us_d  = 1'b0;
    tick_ms_d  = 1'b0;
    div_reg_d  = div_reg_q;
    div_cnt_d  = div_cnt_q;
    tick_div_d = 1'b0;
    div_ack_d  = 1'b0;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    w_apply    = 1'b0;
`ifdef OSC_TICK_SEC_EN
    sec_cnt_d  = sec_cnt_q;
    tick_s_d   = 1'b0;
`endif

    case (state_q)
      ST_SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == c_settle_last) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (en) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_SETTLE;
      end
    endcase

    if (w_active) begin
      // Fractional phase: a tick every time the phase passes one period.
      if (w_sum >= c_freq) begin
        acc_d     = w_wrap[16:0];
        tick_us_d = 1'b1;
        if (us_cnt_q == c_us_last) begin
          us_cnt_d   = '0;
          tick_ms_d  = 1'b1;
          ms_count_d = ms_count_q + 16'd1;
`ifdef OSC_TICK_SEC_EN
          if (sec_cnt_q == c_us_last) begin
            sec_cnt_d = '0;
            tick_s_d  = 1'b1;
          end else begin
            sec_cnt_d = sec_cnt_q + 10'd1;
          end
`endif
        end else begin
          us_cnt_d = us_cnt_q + 10'd1;
        end
      end else begin
        acc_d = w_sum[16:0];
      end

      // Divider: a disabled divider takes a pending value at once, an active
      // one only at its reload point so the running period is never cut short.
      if (div_reg_q == 16'd0) begin
        w_apply = pend_q;
      end else if (div_cnt_q == 16'd0) begin
        tick_div_d = 1'b1;
        div_cnt_d  = div_reg_q;
        w_apply    = pend_q;
      end else begin
        div_cnt_d = div_cnt_q - 16'd1;
      end
    end

    if (w_apply) begin
      div_reg_d = pend_val_q;
      div_cnt_d = pend_val_q;
      div_ack_d = 1'b1;
      pend_d    = 1'b0;
    end

    // Capture after apply so a coincident load becomes the next pending value.
    if (div_load) begin
      pend_d     = 1'b1;
      pend_val_d = div_val;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SETTLE;
      settle_q   <= '0;
      ready_q    <= 1'b0;
      acc_q      <= '0;
      us_cnt_q   <= '0;
      ms_count_q <= '0;
      tick_us_q  <= 1'b0;
      tick_ms_q  <= 1'b0;
      div_reg_q  <= c_div_reset;
      div_cnt_q  <= '0;
      tick_div_q <= 1'b0;
      div_ack_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
`ifdef OSC_TICK_SEC_EN
      sec_cnt_q  <= '0;
      tick_s_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      ready_q    <= ready_d;
      acc_q      <= acc_d;
      us_cnt_q   <= us_cnt_d;
      ms_count_q <= ms_count_d;
      tick_us_q  <= tick_us_d;
      tick_ms_q  <= tick_ms_d;
      div_reg_q  <= div_reg_d;
      div_cnt_q  <= div_cnt_d;
      tick_div_q <= tick_div_d;
      div_ack_q  <= div_ack_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
`ifdef OSC_TICK_SEC_EN
      sec_cnt_q  <= sec_cnt_d;
      tick_s_q   <= tick_s_d;
`endif
    end
  end

  assign ready    = ready_q;
  assign tick_us  = tick_us_q;
  assign tick_ms  = tick_ms_q;
  assign tick_div = tick_div_q;
  assign div_ack  = div_ack_q;
  assign ms_count = ms_count_q;
`ifdef OSC_TICK_SEC_EN
  assign tick_s   = tick_s_q;
`else
  assign tick_s   = 1'b0;
`endif

endmodule
`default_nettype wire
